seg_display_ctrl: RTL and testbench
===================================

Name: seg_display_ctrl

Overview:
- Multi-digit seven-segment display controller.
- Accepts an unsigned binary value on a start strobe and converts it to BCD sequentially (shift-add-3 / double-dabble).
- Latches the result into a display register and drives N_DIGITS static seven-segment outputs, with overflow dashes and optional blinking.
- Sits between datapath results (counters, ALU outputs) and the board HEX displays.

Parameters:
- WIDTH, 10: bit width of the binary input value.
- N_DIGITS, 4: number of displayed decimal digits.
- ACTIVE_LOW, 1: 1 means a segment is lit when driven 0.
- BLINK_DIV, 25_000_000: clk cycles per blink half-period; must be ≥ 1.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a conversion of value; sampled on clk.
- value  input  WIDTH  unsigned binary value, captured when start is accepted.
- blink_en  input  1  when 1, the display blanks on alternate blink half-periods.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when a new result is latched to the display.
- bcd_out  output  N_DIGITS*4  latched BCD result; digit i occupies [4i+3:4i], digit 0 is the least significant.
- seg  output  N_DIGITS*7  segment drives; digit i occupies [7i+6:7i], bit 7i+k is segment a..g for k = 0..6.

Behaviour:
- Reset (async, rst=1) values:
  - FSM goes to IDLE; busy=0, done=0, bcd_out=0.
  - Display register is marked blank, so every seg bit is OFF (all 1s when ACTIVE_LOW=1).
  - Blink counter and blink phase are cleared.
- FSM states: IDLE, SHIFT, LATCH.
  - IDLE: start=1 captures value into a shift register, clears the BCD scratch register, loads the bit counter with WIDTH, and moves to SHIFT.
  - SHIFT: on each cycle, every scratch digit ≥5 first gets +3, then {scratch, shift} shifts left by 1. The counter decrements. After WIDTH shifts the FSM moves to LATCH.
  - LATCH: copies scratch digits and the overflow flag to the display register and pulses done=1 for this cycle. Next state is IDLE.
- busy=1 in SHIFT and LATCH.
- Latency: start sampled at edge 0 → done high during cycle WIDTH+1 → new seg/bcd_out visible from the same edge.
- start while busy=1 is ignored; the request is not queued.
- start in the LATCH cycle is also ignored.
- Overflow:
  - At capture, value ≥ 10^N_DIGITS sets the overflow flag.
  - On latch, all digits then show a dash (segment g only) and bcd_out reads all 4'hF.
  - Scratch width is N_DIGITS digits; overflowing high bits are discarded.
- Display hold: seg and bcd_out hold their last latched result until the next LATCH; they do not change during SHIFT.
- Blink:
  - A free-running counter wraps at BLINK_DIV-1 and toggles the phase on wrap.
  - When blink_en=1 and phase=1, all seg bits are OFF.
  - bcd_out is unaffected by blinking.
  - The counter runs regardless of blink_en.
- Reset asserted mid-conversion aborts it. No done pulse is issued, and the display returns to blank.
- Polarity: seg = ACTIVE_LOW ? ~on_mask : on_mask, applied last.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined: zero digits above the most significant nonzero digit are OFF. Value 0 shows only digit 0 as "0". Overflow dashes are not blanked.
- Undefined: all N_DIGITS digits are always shown, including leading zeros.

Decomposition:
- Package seg_pkg holds:
  - state enum {IDLE, SHIFT, LATCH};
  - constants SEG_DASH (g only) and SEG_BLANK (no segments), both in active-1 form;
  - function digit_to_a2g(logic [3:0]) returning the active-1 mask, with the dash as default.
- One sub-module seg_digit_dec is combinational: BCD digit + blank flag + dash flag → active-1 mask. It is instantiated N_DIGITS times via generate.
- Conversion FSM, blink counter and polarity stage stay in the top level.

Test Plan:
1. Reset mid-run, with WIDTH=10, N_DIGITS=4, ACTIVE_LOW=1:
   - Stimulus: rst pulse during SHIFT.
   - Required: seg=28'hFFFFFFF, busy=0, bcd_out=0, no done pulse.
2. Normal conversion:
   - Stimulus: start with value=1023.
   - Required: busy high for 11 cycles, done pulse in cycle 11, bcd_out=16'h1023.
   - Required seg digits 3..0 = 7'h79, 7'h40, 7'h24, 7'h30.
3. Overflow, with WIDTH=14:
   - Stimulus: start with value=12000.
   - Required: bcd_out=16'hFFFF, every digit = 7'h3F.
   - Stimulus: then value=9999.
   - Required: bcd_out=16'h9999.
4. start while busy:
   - Stimulus: start value=7, then start value=900 two cycles later.
   - Required: exactly one done pulse, bcd_out=16'h0007.
5. Blink, with BLINK_DIV=4:
   - Stimulus: blink_en=1 after latching 1023.
   - Required: seg alternates between the digit pattern and all 1s every 4 cycles; bcd_out is constant.
   - Stimulus: blink_en=0.
   - Required: steady display.
6. Leading-zero blanking, value=5:
   - With SEG_LEADING_ZERO_BLANK_EN: digits 3..1 = 7'h7F, digit 0 = 7'h12.
   - Without it: 7'h40, 7'h40, 7'h40, 7'h12.
   - With SEG_LEADING_ZERO_BLANK_EN, value=0: digit 0 = 7'h40, others 7'h7F.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and segment encodings for the seven-segment display controller.
// Masks here are active-1 (bit k = segment a..g lit); polarity is applied at the top.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_e;

  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Non-decimal codes fall through to a dash so a corrupt digit is visible.
  function automatic logic [6:0] digit_to_a2g(input logic [3:0] d);
    case (d)
      4'd0:    digit_to_a2g = 7'h3F;
      4'd1:    digit_to_a2g = 7'h06;
      4'd2:    digit_to_a2g = 7'h5B;
      4'd3:    digit_to_a2g = 7'h4F;
      4'd4:    digit_to_a2g = 7'h66;
      4'd5:    digit_to_a2g = 7'h6D;
      4'd6:    digit_to_a2g = 7'h7D;
      4'd7:    digit_to_a2g = 7'h07;
      4'd8:    digit_to_a2g = 7'h7F;
      4'd9:    digit_to_a2g = 7'h6F;
      default: digit_to_a2g = SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/seg_digit_dec.sv
// Combinational single-digit decoder: BCD digit plus blank/dash flags to an active-1 mask.
module seg_digit_dec
  import seg_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] mask
);

  // Dash wins over blank so overflow indication is never suppressed.
  always_comb begin
    mask = digit_to_a2g(digit);
    if (blank) mask = SEG_BLANK;
    if (dash)  mask = SEG_DASH;
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// Sequential binary-to-BCD (double-dabble) converter driving N_DIGITS seven-segment digits.
// Optional feature: define SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int WIDTH      = 10,
  parameter int N_DIGITS   = 4,
  parameter int ACTIVE_LOW = 1,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  input  logic                  blink_en,
  output logic                  busy,
  output logic                  done,
  output logic [N_DIGITS*4-1:0] bcd_out,
  output logic [N_DIGITS*7-1:0] seg
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BDW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int DW    = N_DIGITS * 4;
  localparam longint unsigned LIMIT = 64'(10 ** N_DIGITS);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [DW-1:0]    scratch_q, scratch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [DW-1:0]    disp_q, disp_d;
  logic             disp_ovf_q, disp_ovf_d;
  logic             disp_blank_q, disp_blank_d;
  logic [BDW-1:0]   blink_cnt_q, blink_cnt_d;
  logic             phase_q, phase_d;

  logic [DW-1:0]           adj;
  logic [DW-1:0]           scratch_step;
  logic [WIDTH-1:0]        shift_step;
  logic [N_DIGITS-1:0]     digit_blank;
  logic [N_DIGITS*7-1:0]   dec_mask;
  logic [N_DIGITS*7-1:0]   on_mask;

  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (scratch_q[4*i+:4] >= 4'd5) adj[4*i+:4] = scratch_q[4*i+:4] + 4'd3;
    end
    scratch_step = {adj[DW-2:0], shift_q[WIDTH-1]};
    shift_step   = {shift_q[WIDTH-2:0], 1'b0};
  end

  // The display register is loaded on the edge entering LATCH so the new
  // result becomes visible in the same cycle that done is high.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    scratch_d    = scratch_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    disp_d       = disp_q;
    disp_ovf_d   = disp_ovf_q;
    disp_blank_d = disp_blank_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = value;
          scratch_d = '0;
          cnt_d     = CNT_W'(WIDTH);
          ovf_d     = (64'(value) >= LIMIT);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        shift_d   = shift_step;
        scratch_d = scratch_step;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          disp_d       = scratch_step;
          disp_ovf_d   = ovf_q;
          disp_blank_d = 1'b0;
          state_d      = LATCH;
        end
      end
      LATCH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if (blink_cnt_q == BDW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BDW'(1);
      phase_d     = phase_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      scratch_q    <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      disp_q       <= '0;
      disp_ovf_q   <= 1'b0;
      disp_blank_q <= 1'b1;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      scratch_q    <= scratch_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      disp_q       <= disp_d;
      disp_ovf_q   <= disp_ovf_d;
      disp_blank_q <= disp_blank_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
    end
  end

  // Leading-zero suppression scans from the top digit; digit 0 always shows.
  always_comb begin
    digit_blank = '0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    begin
      logic seen;
      seen = 1'b0;
      for (int i = N_DIGITS - 1; i > 0; i--) begin
        seen           = seen | (disp_q[4*i+:4] != 4'd0);
        digit_blank[i] = ~seen;
      end
    end
`endif
  end

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_dig
    seg_digit_dec u_dec (
      .digit (disp_q[4*g+:4]),
      .blank (digit_blank[g]),
      .dash  (disp_ovf_q),
      .mask  (dec_mask[7*g+:7])
    );
  end

  always_comb begin
    on_mask = dec_mask;
    if (disp_blank_q || (blink_en && phase_q)) on_mask = '0;
    seg = (ACTIVE_LOW != 0) ? ~on_mask : on_mask;
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == LATCH);
  assign bcd_out = disp_ovf_q ? {DW{1'b1}} : disp_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl; expected values come from a decimal
// arithmetic model of the display (honours SEG_LEADING_ZERO_BLANK_EN).
module tb_seg_display_ctrl;

  localparam int WIDTH     = 14;
  localparam int N_DIGITS  = 4;
  localparam int BLINK_DIV = 4;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic [WIDTH-1:0]      value;
  logic                  blink_en;
  logic                  busy;
  logic                  done;
  logic [N_DIGITS*4-1:0] bcd_out;
  logic [N_DIGITS*7-1:0] seg;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  int unsigned disp_v     = 0;
  bit          disp_blank = 1'b1;

  logic [6:0] font [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  seg_display_ctrl #(
    .WIDTH      (WIDTH),
    .N_DIGITS   (N_DIGITS),
    .ACTIVE_LOW (1),
    .BLINK_DIV  (BLINK_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .value    (value),
    .blink_en (blink_en),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .seg      (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  function automatic bit blink_phase();
    return ((edges / BLINK_DIV) % 2) == 1;
  endfunction

  function automatic logic [15:0] model_bcd(input int unsigned v, input bit blank);
    logic [15:0] r;
    int unsigned p;
    r = '0;
    p = 1;
    if (blank) return 16'h0000;
    if (v >= 10000) return 16'hFFFF;
    for (int i = 0; i < N_DIGITS; i++) begin
      r[4*i+:4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [27:0] model_seg(input int unsigned v, input bit blank, input bit off);
    logic [27:0] r;
    logic [6:0]  m;
    int unsigned p;
    p = 1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (v >= 10000) m = 7'h40;
      else            m = font[(v / p) % 10];
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (v < 10000 && i > 0 && v < p) m = 7'h00;
`endif
      if (blank || off) m = 7'h00;
      r[7*i+:7] = ~m;
      p = p * 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one conversion; optionally pulses a second start at cycle 'at' (0 = none).
  task automatic convert(input int unsigned v, input int unsigned v2, input int at);
    int busy_n;
    int done_n;
    int done_at;
    busy_n  = 0;
    done_n  = 0;
    done_at = 0;
    @(negedge clk);
    start = 1'b1;
    value = WIDTH'(v);
    for (int k = 1; k <= WIDTH + 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == at) begin
        start = 1'b1;
        value = WIDTH'(v2);
      end
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_at = k;
      end
      if (k == WIDTH / 2) begin
        check("hold_bcd", 64'(bcd_out), 64'(model_bcd(disp_v, disp_blank)));
        check("hold_seg", 64'(seg), 64'(model_seg(disp_v, disp_blank, 1'b0)));
      end
      if (k == WIDTH + 1) check("bcd_at_done", 64'(bcd_out), 64'(model_bcd(v, 1'b0)));
    end
    disp_v     = v;
    disp_blank = 1'b0;
    check("busy_cycles", 64'(busy_n), 64'(WIDTH + 1));
    check("done_count", 64'(done_n), 64'd1);
    check("done_cycle", 64'(done_at), 64'(WIDTH + 1));
    check("bcd", 64'(bcd_out), 64'(model_bcd(v, 1'b0)));
    check("seg", 64'(seg), 64'(model_seg(v, 1'b0, 1'b0)));
  endtask

  initial begin
    int done_n;
    int unsigned v;
    rst      = 1'b1;
    start    = 1'b0;
    value    = '0;
    blink_en = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_seg", 64'(seg), 64'h0FFF_FFFF);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_bcd", 64'(bcd_out), 64'd0);
    rst = 1'b0;

    convert(1023, 0, 0);
    check("seg_1023", 64'(seg), 64'({7'h79, 7'h40, 7'h24, 7'h30}));
    check("bcd_1023", 64'(bcd_out), 64'h1023);

    blink_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("blink_seg", 64'(seg), 64'(model_seg(disp_v, 1'b0, blink_phase())));
      check("blink_bcd", 64'(bcd_out), 64'h1023);
    end
    blink_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("steady_seg", 64'(seg), 64'(model_seg(disp_v, 1'b0, 1'b0)));
    end

    convert(12000, 0, 0);
    check("ovf_bcd", 64'(bcd_out), 64'hFFFF);
    check("ovf_seg", 64'(seg), 64'({7'h3F, 7'h3F, 7'h3F, 7'h3F}));
    convert(9999, 0, 0);
    check("bcd_9999", 64'(bcd_out), 64'h9999);

    convert(7, 900, 2);
    check("bcd_busy_ignored", 64'(bcd_out), 64'h0007);
    convert(4321, 55, WIDTH + 1);

    convert(5, 0, 0);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    check("lz_5", 64'(seg), 64'({7'h7F, 7'h7F, 7'h7F, 7'h12}));
    convert(0, 0, 0);
    check("lz_0", 64'(seg), 64'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
`else
    check("nolz_5", 64'(seg), 64'({7'h40, 7'h40, 7'h40, 7'h12}));
`endif

    for (int n = 0; n < 16; n++) begin
      v = (n % 2 == 0) ? $urandom_range(0, 9999) : $urandom_range(0, 16383);
      convert(v, 0, 0);
    end

    @(negedge clk);
    start = 1'b1;
    value = WIDTH'(500);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_seg", 64'(seg), 64'h0FFF_FFFF);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_bcd", 64'(bcd_out), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst        = 1'b0;
    disp_blank = 1'b1;
    disp_v     = 0;
    done_n     = 0;
    for (int i = 0; i < WIDTH + 6; i++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    check("midrst_no_done", 64'(done_n), 64'd0);
    check("midrst_idle", 64'(busy), 64'd0);
    check("midrst_hold", 64'(seg), 64'h0FFF_FFFF);

    convert(2468, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
